// File: rtl/rf_param.sv
// Parametrised register file with two read ports and one write port. Each access starts on a
// rising edge of start. Also supports optional bypass, an optional zero register and a bulk clear.
module rf_param #(
  parameter int unsigned REG_SIZE     = 32,
  parameter int unsigned REGFILE_SIZE = 32,
  parameter int unsigned INDEX_SIZE   = 5,
  parameter int unsigned ZERO_REG_EN  = 1,
  parameter int unsigned BYPASS_EN    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [INDEX_SIZE-1:0] read_addr_s,
  input  logic [INDEX_SIZE-1:0] read_addr_t,
  input  logic [INDEX_SIZE-1:0] write_addr,
  input  logic                  write_enabled,
  input  logic [REG_SIZE-1:0]   write_data,
  input  logic                  clear,
  output logic                  busy,
  output logic                  finish,
  output logic [REG_SIZE-1:0]   outA,
  output logic [REG_SIZE-1:0]   outB
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                  state_q;
  logic                    start_q;
  logic [INDEX_SIZE-1:0]   cnt_q;
  logic [REG_SIZE-1:0]     mem_q [REGFILE_SIZE];
  logic                    req;

  assign req = start & ~start_q;

  function automatic logic in_range(input logic [INDEX_SIZE-1:0] a);
    return 32'(a) < REGFILE_SIZE;
  endfunction

  function automatic logic is_zero_reg(input logic [INDEX_SIZE-1:0] a);
    return (ZERO_REG_EN != 0) && (a == '0);
  endfunction

  // Called from the clocked block, so it sees the pre-edge register contents.
  function automatic logic [REG_SIZE-1:0] read_port(input logic [INDEX_SIZE-1:0] a);
    if (!in_range(a) || is_zero_reg(a)) begin
      return '0;
    end
    if ((BYPASS_EN != 0) && write_enabled && (a == write_addr)) begin
      return write_data;
    end
    return mem_q[a];
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      finish  <= 1'b0;
      outA    <= '0;
      outB    <= '0;
      for (int unsigned i = 0; i < REGFILE_SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      start_q <= start;
      finish  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A clear wins over a simultaneous request; that request is dropped.
          if (clear) begin
            state_q <= StClear;
            busy    <= 1'b1;
            cnt_q   <= '0;
          end else if (req) begin
            outA   <= read_port(read_addr_s);
            outB   <= read_port(read_addr_t);
            finish <= 1'b1;
            if (write_enabled && in_range(write_addr) && !is_zero_reg(write_addr)) begin
              mem_q[write_addr] <= write_data;
            end
          end
        end
        StClear: begin
          mem_q[cnt_q] <= '0;
          cnt_q        <= cnt_q + 1'b1;
          if (cnt_q == INDEX_SIZE'(REGFILE_SIZE - 1)) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_param.sv
// Bench for rf_param: two instances (read-first/zero-reg/full size and write-first/no-zero/24 regs)
// driven by shared stimulus and checked every cycle against a behavioural model.
module tb_rf_param;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        write_enabled = 1'b0;
  logic        clear = 1'b0;
  logic [4:0]  read_addr_s = '0;
  logic [4:0]  read_addr_t = '0;
  logic [4:0]  write_addr = '0;
  logic [31:0] write_data = '0;

  logic        busy0, fin0, busy1, fin1;
  logic [31:0] a0, b0, a1, b1;

  int n_tests = 0;
  int n_fail  = 0;

  rf_param u_dut0 (
    .clock(clock), .reset(reset), .start(start), .read_addr_s(read_addr_s),
    .read_addr_t(read_addr_t), .write_addr(write_addr), .write_enabled(write_enabled),
    .write_data(write_data), .clear(clear), .busy(busy0), .finish(fin0), .outA(a0), .outB(b0)
  );

  rf_param #(.REGFILE_SIZE(24), .ZERO_REG_EN(0), .BYPASS_EN(1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start), .read_addr_s(read_addr_s),
    .read_addr_t(read_addr_t), .write_addr(write_addr), .write_enabled(write_enabled),
    .write_data(write_data), .clear(clear), .busy(busy1), .finish(fin1), .outA(a1), .outB(b1)
  );

  always #5 clock = ~clock;

  // Model: register contents, remaining busy cycles and expected outputs per instance.
  logic [31:0] m_reg [2][32];
  int          busy_left [2];
  logic        m_start_prev;
  logic        e_fin [2];
  logic [31:0] e_a [2];
  logic [31:0] e_b [2];

  function automatic int sz(int d);
    return (d == 0) ? 32 : 24;
  endfunction

  function automatic logic [31:0] m_read(int d, logic [4:0] a);
    if (int'(a) >= sz(d)) return 32'h0;
    if (d == 0 && a == 5'd0) return 32'h0;
    if (d == 1 && write_enabled && a == write_addr) return write_data;
    return m_reg[d][a];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) m_reg[d][i] = 32'h0;
      busy_left[d] = 0;
      e_fin[d] = 1'b0;
      e_a[d] = 32'h0;
      e_b[d] = 32'h0;
    end
    m_start_prev = 1'b0;
  endtask

  task automatic model_step();
    logic req;
    if (reset) begin
      model_reset();
      return;
    end
    req = start && !m_start_prev;
    m_start_prev = start;
    for (int d = 0; d < 2; d++) begin
      e_fin[d] = 1'b0;
      if (busy_left[d] > 0) begin
        busy_left[d]--;
      end else if (clear) begin
        busy_left[d] = sz(d);
        for (int i = 0; i < 32; i++) m_reg[d][i] = 32'h0;
      end else if (req) begin
        e_a[d] = m_read(d, read_addr_s);
        e_b[d] = m_read(d, read_addr_t);
        e_fin[d] = 1'b1;
        if (write_enabled && int'(write_addr) < sz(d) && !(d == 0 && write_addr == 5'd0))
          m_reg[d][write_addr] = write_data;
      end
    end
  endtask

  always @(negedge clock) begin
    check("busy0", 32'(busy0), 32'(busy_left[0] > 0));
    check("fin0", 32'(fin0), 32'(e_fin[0]));
    check("outA0", a0, e_a[0]);
    check("outB0", b0, e_b[0]);
    check("busy1", 32'(busy1), 32'(busy_left[1] > 0));
    check("fin1", 32'(fin1), 32'(e_fin[1]));
    check("outA1", a1, e_a[1]);
    check("outB1", b1, e_b[1]);
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic access(logic we, logic [4:0] wa, logic [31:0] wd, logic [4:0] rs, logic [4:0] rt);
    start = 1'b1; write_enabled = we; write_addr = wa; write_data = wd;
    read_addr_s = rs; read_addr_t = rt;
    tick();
    start = 1'b0; write_enabled = 1'b0;
    tick();
  endtask

  initial begin
    int nf, n0, n1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_outA", a0, 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_fin", 32'(fin0), 32'h0);

    // Write then read, with finish timing.
    start = 1'b1; write_enabled = 1'b1; write_addr = 5'd5; write_data = 32'hDEADBEEF;
    tick();
    check("fin_pulse", 32'(fin0), 32'h1);
    start = 1'b0; write_enabled = 1'b0;
    tick();
    check("fin_drop", 32'(fin0), 32'h0);
    access(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    check("wr_rd_a", a0, 32'hDEADBEEF);
    check("wr_rd_b", b0, 32'h0);

    // Zero register.
    access(1'b1, 5'd0, 32'h1234, 5'd1, 5'd1);
    access(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check("zero_on", a0, 32'h0);
    check("zero_off", a1, 32'h1234);

    // Collision: read-first versus write-first.
    access(1'b1, 5'd7, 32'h11, 5'd0, 5'd0);
    access(1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
    check("coll_rf", a0, 32'h11);
    check("coll_wf", a1, 32'h22);
    access(1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    check("coll_after0", a0, 32'h22);
    check("coll_after1", a1, 32'h22);

    // Out-of-range address on the 24-entry instance.
    access(1'b1, 5'd25, 32'hAA, 5'd1, 5'd1);
    access(1'b0, 5'd0, 32'h0, 5'd25, 5'd0);
    check("oor_in", a0, 32'hAA);
    check("oor_drop", a1, 32'h0);

    // Start held high: one request, one write.
    nf = 0;
    start = 1'b1; write_enabled = 1'b1; write_addr = 5'd9; write_data = 32'h99;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fin0) nf++;
      write_data = 32'h55;
    end
    start = 1'b0; write_enabled = 1'b0;
    tick();
    check("held_fin", 32'(nf), 32'h1);
    access(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    check("held_wr", a0, 32'h99);

    // Fill, then clear together with start.
    for (int i = 1; i < 32; i++) access(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
    start = 1'b1; clear = 1'b1;
    tick();
    clear = 1'b0;
    n0 = 0; n1 = 0; nf = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (fin0 || fin1) nf++;
      tick();
    end
    start = 1'b0;
    tick();
    check("clr_busy0", 32'(n0), 32'd32);
    check("clr_busy1", 32'(n1), 32'd24);
    check("clr_fin", 32'(nf), 32'h0);
    for (int i = 0; i < 32; i++) begin
      access(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check("clr_rd", a0 | b0, 32'h0);
    end

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      start = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 39) == 0);
      write_enabled = 1'($urandom_range(0, 1));
      write_addr = 5'($urandom);
      read_addr_s = 5'($urandom);
      read_addr_t = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom);
      write_data = $urandom;
      tick();
    end
    start = 1'b0; clear = 1'b0; write_enabled = 1'b0;
    repeat (35) tick();

    // Asynchronous reset in the middle of a clear.
    access(1'b1, 5'd3, 32'hABCD, 5'd0, 5'd0);
    access(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check("pre_rst", a0, 32'hABCD);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (10) tick();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check("arst_busy0", 32'(busy0), 32'h0);
    check("arst_fin0", 32'(fin0), 32'h0);
    check("arst_outA0", a0, 32'h0);
    check("arst_outB0", b0, 32'h0);
    check("arst_busy1", 32'(busy1), 32'h0);
    check("arst_outA1", a1, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("arst_idle", 32'(busy0), 32'h0);
    for (int i = 0; i < 32; i++) begin
      access(1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
      check("arst_rd", a0 | a1, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
